// File: rtl/wb_commit_unit.sv
// Write-back/commit stage for the N-thread in-order core with precise ITLB/DTLB exception arbitration.
// Optional macro WB_PERF_COUNTERS_EN adds per-thread retired counters and an exception counter.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  S_NORMAL | all threads commit; a TLB miss elects its thread as master
//  S_ACTIVE | only the master commits; others replay until the master irets
module wb_commit_unit #(
    parameter int                N_THREADS      = 4,
    parameter int                XLEN           = 32,
    parameter int                REG_AW         = 5,
    parameter int                VPN_W          = 20,
    parameter int                PPN_W          = 8,
    parameter logic [XLEN-1:0]   BOOT_PC_BASE   = 'h1000,
    parameter logic [XLEN-1:0]   BOOT_PC_STRIDE = 'h0,
    parameter logic [XLEN-1:0]   EXC_PC         = 'h2000,
    localparam int               TID_W          = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tl_valid,
    input  logic                 tl_ok,
    input  logic [TID_W-1:0]     tl_thread,
    input  logic [XLEN-1:0]      tl_pc,
    input  logic                 tl_itlb_miss,
    input  logic                 tl_dtlb_miss,
    input  logic [REG_AW-1:0]    tl_dst,
    input  logic [XLEN-1:0]      tl_data,
    input  logic [XLEN-1:0]      tl_mul,
    input  logic [XLEN-1:0]      tl_r2,
    input  logic                 tl_is_mul,
    input  logic                 tl_wr_reg,
    input  logic                 tl_jump,
    input  logic                 tl_branch,
    input  logic                 tl_taken,
    input  logic                 tl_iret,
    input  logic [1:0]           tl_tlbwr,
    output logic                 rf_wen,
    output logic [TID_W-1:0]     rf_thread,
    output logic [REG_AW-1:0]    rf_addr,
    output logic [XLEN-1:0]      rf_data,
    output logic                 itlb_wen,
    output logic                 dtlb_wen,
    output logic [VPN_W-1:0]     tlb_vpn,
    output logic [PPN_W-1:0]     tlb_ppn,
    output logic                 redir_en,
    output logic [TID_W-1:0]     redir_thread,
    output logic [XLEN-1:0]      redir_pc,
    output logic                 exc_en,
    output logic [TID_W-1:0]     exc_thread,
    output logic [XLEN-1:0]      exc_epc,
    output logic [XLEN-1:0]      exc_addr,
    output logic [1:0]           exc_cause,
    output logic                 priv,
    output logic                 dbl_fault
`ifdef WB_PERF_COUNTERS_EN
    ,
    output logic [XLEN-1:0]      retired [N_THREADS],
    output logic [XLEN-1:0]      exc_count
`endif
);

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [TID_W-1:0]  master;
    logic [TID_W-1:0]  master_d;
    logic [XLEN-1:0]   wait_pc [N_THREADS];

    logic              thread_ok;
    logic              accept;
    logic              is_master;
    logic              fault;
    logic              enter_exc;
    logic              commit;
    logic              replay;
    logic              taken;
    logic              do_iret;

    logic              rf_wen_d;
    logic              itlb_wen_d;
    logic              dtlb_wen_d;
    logic              redir_en_d;
    logic [XLEN-1:0]   redir_pc_d;
    logic              wpc_we;
    logic [XLEN-1:0]   wpc_d;
    logic              priv_d;
    logic              dbl_d;

    // Ids beyond N_THREADS (non power-of-two configs) are treated as wrong-path.
    assign thread_ok = (32'(tl_thread) < N_THREADS);
    assign accept    = tl_valid && thread_ok && (tl_pc == wait_pc[tl_thread]);
    assign is_master = (tl_thread == master);
    assign fault     = !tl_ok && (tl_itlb_miss || tl_dtlb_miss);
    assign enter_exc = accept && (state == S_NORMAL) && fault;
    assign commit    = accept && tl_ok && ((state == S_NORMAL) || is_master);
    assign replay    = accept && !commit && !enter_exc;
    assign taken     = tl_jump && (!tl_branch || tl_taken);
    assign do_iret   = commit && taken && tl_iret;

    assign exc_en     = (state == S_ACTIVE);
    assign exc_thread = master;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_NORMAL;
            master <= '0;
        end else begin
            state  <= state_d;
            master <= master_d;
        end
    end

    always_comb begin
        state_d  = state;
        master_d = master;
        case (state)
            S_NORMAL: begin
                if (enter_exc) begin
                    state_d  = S_ACTIVE;
                    master_d = tl_thread;
                end
            end
            S_ACTIVE: begin
                if (do_iret) begin
                    state_d = S_NORMAL;
                end
            end
            default: state_d = S_NORMAL;
        endcase
    end

    always_comb begin
        rf_wen_d   = commit && tl_wr_reg;
        itlb_wen_d = commit && (tl_tlbwr == 2'd1);
        dtlb_wen_d = commit && (tl_tlbwr == 2'd2);
        redir_en_d = enter_exc || replay || (commit && taken);
        redir_pc_d = redir_pc;
        wpc_we     = enter_exc || commit;
        wpc_d      = tl_pc + XLEN'(4);
        priv_d     = priv;
        dbl_d      = dbl_fault;
        if (enter_exc) begin
            redir_pc_d = EXC_PC;
            wpc_d      = EXC_PC;
            priv_d     = 1'b1;
        end else if (replay) begin
            redir_pc_d = tl_pc;
            // Only the master can fault while already in the handler.
            if ((state == S_ACTIVE) && is_master && fault) begin
                dbl_d = 1'b1;
            end
        end else if (commit && taken) begin
            redir_pc_d = tl_iret ? exc_epc : tl_data;
            wpc_d      = redir_pc_d;
            if (tl_iret) begin
                priv_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen       <= 1'b0;
            rf_thread    <= '0;
            rf_addr      <= '0;
            rf_data      <= '0;
            itlb_wen     <= 1'b0;
            dtlb_wen     <= 1'b0;
            tlb_vpn      <= '0;
            tlb_ppn      <= '0;
            redir_en     <= 1'b0;
            redir_thread <= '0;
            redir_pc     <= '0;
            exc_epc      <= '0;
            exc_addr     <= '0;
            exc_cause    <= '0;
            priv         <= 1'b0;
            dbl_fault    <= 1'b0;
            for (int t = 0; t < N_THREADS; t++) begin
                wait_pc[t] <= BOOT_PC_BASE + XLEN'(t) * BOOT_PC_STRIDE;
            end
        end else begin
            rf_wen    <= rf_wen_d;
            itlb_wen  <= itlb_wen_d;
            dtlb_wen  <= dtlb_wen_d;
            redir_en  <= redir_en_d;
            priv      <= priv_d;
            dbl_fault <= dbl_d;
            if (rf_wen_d) begin
                rf_thread <= tl_thread;
                rf_addr   <= tl_dst;
                rf_data   <= tl_is_mul ? tl_mul : tl_data;
            end
            if (itlb_wen_d || dtlb_wen_d) begin
                tlb_vpn <= tl_data[VPN_W-1:0];
                tlb_ppn <= tl_r2[PPN_W-1:0];
            end
            if (redir_en_d) begin
                redir_thread <= tl_thread;
                redir_pc     <= redir_pc_d;
            end
            if (wpc_we) begin
                wait_pc[tl_thread] <= wpc_d;
            end
            // ITLB wins when both miss bits are set.
            if (enter_exc) begin
                exc_epc   <= tl_pc;
                exc_addr  <= tl_itlb_miss ? tl_pc : tl_data;
                exc_cause <= tl_itlb_miss ? 2'd1 : 2'd2;
            end
        end
    end

`ifdef WB_PERF_COUNTERS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < N_THREADS; t++) begin
                retired[t] <= '0;
            end
            exc_count <= '0;
        end else begin
            if (commit) begin
                retired[tl_thread] <= retired[tl_thread] + XLEN'(1);
            end
            if (enter_exc) begin
                exc_count <= exc_count + XLEN'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Scoreboard bench for wb_commit_unit: a reference model pushes expected outputs per driven cycle,
// which are popped and compared one cycle later.
module tb_wb_commit_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        tl_valid, tl_ok, tl_itlb_miss, tl_dtlb_miss;
    logic [1:0]  tl_thread;
    logic [31:0] tl_pc, tl_data, tl_mul, tl_r2;
    logic [4:0]  tl_dst;
    logic        tl_is_mul, tl_wr_reg, tl_jump, tl_branch, tl_taken, tl_iret;
    logic [1:0]  tl_tlbwr;
    logic        rf_wen, itlb_wen, dtlb_wen, redir_en, exc_en, priv, dbl_fault;
    logic [1:0]  rf_thread, redir_thread, exc_thread, exc_cause;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data, redir_pc, exc_epc, exc_addr;
    logic [19:0] tlb_vpn;
    logic [7:0]  tlb_ppn;

    always #5 clk = ~clk;

    wb_commit_unit dut (
        .clk(clk), .rst(rst),
        .tl_valid(tl_valid), .tl_ok(tl_ok), .tl_thread(tl_thread), .tl_pc(tl_pc),
        .tl_itlb_miss(tl_itlb_miss), .tl_dtlb_miss(tl_dtlb_miss), .tl_dst(tl_dst),
        .tl_data(tl_data), .tl_mul(tl_mul), .tl_r2(tl_r2),
        .tl_is_mul(tl_is_mul), .tl_wr_reg(tl_wr_reg), .tl_jump(tl_jump), .tl_branch(tl_branch),
        .tl_taken(tl_taken), .tl_iret(tl_iret), .tl_tlbwr(tl_tlbwr),
        .rf_wen(rf_wen), .rf_thread(rf_thread), .rf_addr(rf_addr), .rf_data(rf_data),
        .itlb_wen(itlb_wen), .dtlb_wen(dtlb_wen), .tlb_vpn(tlb_vpn), .tlb_ppn(tlb_ppn),
        .redir_en(redir_en), .redir_thread(redir_thread), .redir_pc(redir_pc),
        .exc_en(exc_en), .exc_thread(exc_thread), .exc_epc(exc_epc), .exc_addr(exc_addr),
        .exc_cause(exc_cause), .priv(priv), .dbl_fault(dbl_fault)
    );

    typedef struct packed {
        logic        valid, ok;
        logic [1:0]  th;
        logic [31:0] pc;
        logic        im, dm;
        logic [4:0]  dst;
        logic [31:0] data, mul, r2;
        logic        is_mul, wr, jump, branch, taken, iret;
        logic [1:0]  tlbwr;
    } in_t;

    typedef struct packed {
        logic        rf_wen;
        logic [1:0]  rf_thread;
        logic [4:0]  rf_addr;
        logic [31:0] rf_data;
        logic        itlb_wen, dtlb_wen;
        logic [19:0] vpn;
        logic [7:0]  ppn;
        logic        redir_en;
        logic [1:0]  redir_thread;
        logic [31:0] redir_pc;
        logic        exc_en;
        logic [1:0]  exc_thread;
        logic [31:0] exc_epc, exc_addr;
        logic [1:0]  exc_cause;
        logic        priv, dbl;
    } out_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    out_t  expq[$];

    out_t        m;
    logic [31:0] m_wait [4];
    logic        m_active;
    logic [1:0]  m_master;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m        = '0;
        m_active = 1'b0;
        m_master = 2'd0;
        for (int t = 0; t < 4; t++) m_wait[t] = 32'h1000;
    endtask

    // Spec-level behaviour: decides accept/fault/commit/replay and updates expected outputs.
    task automatic model_step(input in_t i);
        logic acc, flt, tk;
        m.rf_wen   = 1'b0;
        m.itlb_wen = 1'b0;
        m.dtlb_wen = 1'b0;
        m.redir_en = 1'b0;
        acc = i.valid && (i.pc == m_wait[i.th]);
        flt = !i.ok && (i.im || i.dm);
        tk  = i.jump && (!i.branch || i.taken);
        if (acc) begin
            if (!m_active && flt) begin
                m.redir_en = 1'b1; m.redir_thread = i.th; m.redir_pc = 32'h2000;
                m_wait[i.th] = 32'h2000;
                m.exc_epc   = i.pc;
                m.exc_addr  = i.im ? i.pc : i.data;
                m.exc_cause = i.im ? 2'd1 : 2'd2;
                m.priv      = 1'b1;
                m_active    = 1'b1;
                m_master    = i.th;
            end else if (i.ok && (!m_active || i.th == m_master)) begin
                m_wait[i.th] = i.pc + 32'd4;
                if (i.wr) begin
                    m.rf_wen = 1'b1; m.rf_thread = i.th; m.rf_addr = i.dst;
                    m.rf_data = i.is_mul ? i.mul : i.data;
                end
                if (i.tlbwr == 2'd1 || i.tlbwr == 2'd2) begin
                    m.itlb_wen = (i.tlbwr == 2'd1);
                    m.dtlb_wen = (i.tlbwr == 2'd2);
                    m.vpn = i.data[19:0];
                    m.ppn = i.r2[7:0];
                end
                if (tk) begin
                    m.redir_en = 1'b1; m.redir_thread = i.th;
                    if (i.iret) begin
                        m.redir_pc = m.exc_epc;
                        m.priv     = 1'b0;
                        m_active   = 1'b0;
                    end else begin
                        m.redir_pc = i.data;
                    end
                    m_wait[i.th] = m.redir_pc;
                end
            end else begin
                m.redir_en = 1'b1; m.redir_thread = i.th; m.redir_pc = i.pc;
                if (m_active && i.th == m_master && flt) m.dbl = 1'b1;
            end
        end
        m.exc_en     = m_active;
        m.exc_thread = m_master;
    endtask

    task automatic compare(input out_t e);
        chk("rf_wen", 64'(rf_wen), 64'(e.rf_wen));
        chk("rf_thread", 64'(rf_thread), 64'(e.rf_thread));
        chk("rf_addr", 64'(rf_addr), 64'(e.rf_addr));
        chk("rf_data", 64'(rf_data), 64'(e.rf_data));
        chk("itlb_wen", 64'(itlb_wen), 64'(e.itlb_wen));
        chk("dtlb_wen", 64'(dtlb_wen), 64'(e.dtlb_wen));
        chk("tlb_vpn", 64'(tlb_vpn), 64'(e.vpn));
        chk("tlb_ppn", 64'(tlb_ppn), 64'(e.ppn));
        chk("redir_en", 64'(redir_en), 64'(e.redir_en));
        chk("redir_thread", 64'(redir_thread), 64'(e.redir_thread));
        chk("redir_pc", 64'(redir_pc), 64'(e.redir_pc));
        chk("exc_en", 64'(exc_en), 64'(e.exc_en));
        chk("exc_thread", 64'(exc_thread), 64'(e.exc_thread));
        chk("exc_epc", 64'(exc_epc), 64'(e.exc_epc));
        chk("exc_addr", 64'(exc_addr), 64'(e.exc_addr));
        chk("exc_cause", 64'(exc_cause), 64'(e.exc_cause));
        chk("priv", 64'(priv), 64'(e.priv));
        chk("dbl_fault", 64'(dbl_fault), 64'(e.dbl));
    endtask

    task automatic apply(input in_t i);
        tl_valid = i.valid; tl_ok = i.ok; tl_thread = i.th; tl_pc = i.pc;
        tl_itlb_miss = i.im; tl_dtlb_miss = i.dm; tl_dst = i.dst;
        tl_data = i.data; tl_mul = i.mul; tl_r2 = i.r2;
        tl_is_mul = i.is_mul; tl_wr_reg = i.wr; tl_jump = i.jump; tl_branch = i.branch;
        tl_taken = i.taken; tl_iret = i.iret; tl_tlbwr = i.tlbwr;
    endtask

    function automatic in_t mk(input logic [1:0] th, input logic [31:0] pc);
        in_t i;
        i = '0;
        i.valid = 1'b1; i.ok = 1'b1; i.th = th; i.pc = pc;
        return i;
    endfunction

    task automatic step(input in_t i);
        out_t e;
        apply(i);
        model_step(i);
        expq.push_back(m);
        @(posedge clk);
        #1;
        if (expq.size() == 0) begin
            chk("scoreboard_empty", 64'd0, 64'd1);
        end else begin
            e = expq.pop_front();
            compare(e);
        end
        apply('0);
    endtask

    // Reset is asserted with `busy` traffic on the inputs to show reset wins over it.
    task automatic do_reset(input in_t busy);
        rst = 1'b1;
        apply(busy);
        @(posedge clk);
        #1;
        model_reset();
        compare(m);
        chk("rst_exc_en", 64'(exc_en), 64'd0);
        chk("rst_redir_en", 64'(redir_en), 64'd0);
        chk("rst_priv", 64'(priv), 64'd0);
        rst = 1'b0;
        apply('0);
    endtask

    initial begin
        in_t i;
        rst = 1'b1;
        apply('0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset('0);

        i = mk(2'd2, 32'h1000); i.wr = 1; i.dst = 5'd3; i.data = 32'd7; step(i);
        chk("t2_rf_wen", 64'(rf_wen), 64'd1);
        chk("t2_rf_thread", 64'(rf_thread), 64'd2);
        chk("t2_rf_addr", 64'(rf_addr), 64'd3);
        chk("t2_rf_data", 64'(rf_data), 64'd7);

        step(mk(2'd1, 32'h1000));
        i = mk(2'd1, 32'h2000); i.wr = 1; step(i);
        chk("stale_rf_wen", 64'(rf_wen), 64'd0);
        chk("stale_redir_en", 64'(redir_en), 64'd0);
        i = mk(2'd1, 32'h1004); i.wr = 1; i.dst = 5'd9; step(i);
        chk("t1_wait_1004", 64'(rf_wen), 64'd1);

        i = mk(2'd0, 32'h1000); i.ok = 0; i.dm = 1; i.data = 32'hABC0; step(i);
        chk("flt_redir_pc", 64'(redir_pc), 64'h2000);
        chk("flt_exc_en", 64'(exc_en), 64'd1);
        chk("flt_cause", 64'(exc_cause), 64'd2);
        chk("flt_addr", 64'(exc_addr), 64'hABC0);
        chk("flt_priv", 64'(priv), 64'd1);

        i = mk(2'd3, 32'h1000); i.wr = 1; step(i);
        chk("nm_replay_pc", 64'(redir_pc), 64'h1000);
        chk("nm_replay_thr", 64'(redir_thread), 64'd3);
        chk("nm_no_rf", 64'(rf_wen), 64'd0);

        i = mk(2'd0, 32'h2000); i.ok = 0; i.dm = 1; step(i);
        chk("dbl_fault", 64'(dbl_fault), 64'd1);

        step(mk(2'd0, 32'h2000));
        i = mk(2'd0, 32'h2004); i.jump = 1; i.iret = 1; step(i);
        chk("iret_pc", 64'(redir_pc), 64'h1000);
        chk("iret_exc_en", 64'(exc_en), 64'd0);
        chk("iret_priv", 64'(priv), 64'd0);

        i = mk(2'd3, 32'h1000); i.jump = 1; i.branch = 1; i.data = 32'h3000; step(i);
        chk("br_nt_redir", 64'(redir_en), 64'd0);
        i = mk(2'd3, 32'h1004); i.jump = 1; i.branch = 1; i.taken = 1; i.data = 32'h3000; step(i);
        chk("br_t_pc", 64'(redir_pc), 64'h3000);

        i = mk(2'd3, 32'h3000); i.tlbwr = 2'd2; i.data = 32'h12345; i.r2 = 32'h7F; step(i);
        chk("dtlb_wen", 64'(dtlb_wen), 64'd1);
        chk("tlb_vpn", 64'(tlb_vpn), 64'h12345);
        chk("tlb_ppn", 64'(tlb_ppn), 64'h7F);
        i = mk(2'd3, 32'h3004); i.tlbwr = 2'd1; i.data = 32'hABCDE; i.r2 = 32'h11; step(i);
        i = mk(2'd3, 32'h3008); i.tlbwr = 2'd3; step(i);

        i = mk(2'd2, 32'h1004); i.jump = 1; i.data = 32'hFFFF_FFFC; step(i);
        step(mk(2'd2, 32'hFFFF_FFFC));
        i = mk(2'd2, 32'h0); i.wr = 1; step(i);
        chk("wrap_commit", 64'(rf_wen), 64'd1);

        i = mk(2'd1, 32'h1008); i.ok = 0; i.im = 1; i.dm = 1; i.data = 32'h5555; step(i);
        chk("prio_cause", 64'(exc_cause), 64'd1);
        chk("prio_addr", 64'(exc_addr), 64'h1008);
        i = mk(2'd1, 32'h2000); i.wr = 1; i.is_mul = 1; i.data = 32'd5; i.mul = 32'd9; step(i);
        chk("mul_data", 64'(rf_data), 64'd9);

        i = mk(2'd1, 32'h2004); i.ok = 0; i.im = 1; i.wr = 1; i.jump = 1;
        do_reset(i);

        for (int k = 0; k < 600; k++) begin
            i = '0;
            i.valid  = ($urandom_range(0, 7) != 0);
            i.th     = m_active && $urandom_range(0, 1) ? m_master : 2'($urandom_range(0, 3));
            i.pc     = ($urandom_range(0, 7) == 0) ? $urandom : m_wait[i.th];
            i.ok     = ($urandom_range(0, 4) != 0);
            i.im     = ($urandom_range(0, 3) == 0);
            i.dm     = ($urandom_range(0, 2) == 0);
            i.dst    = 5'($urandom);
            i.data   = $urandom;
            i.mul    = $urandom;
            i.r2     = $urandom;
            i.is_mul = 1'($urandom);
            i.wr     = 1'($urandom);
            i.jump   = ($urandom_range(0, 3) == 0);
            i.branch = 1'($urandom);
            i.taken  = 1'($urandom);
            i.iret   = m_active ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            i.tlbwr  = 2'($urandom);
            step(i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
